// File: rtl/ddr_rfifo_filler.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rfifo_filler
// Brief    : Fetches a block of 32-bit words over AXI4 read bursts and pushes
//            them into the read-path async FIFO (write-clock domain).
// Revision : 1.0 - initial release
// ============================================================================
module ddr_rfifo_filler #(
  parameter int ADDR_W    = 28,
  parameter int CNT_W     = 20,
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 32
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  total_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  input  logic              fifo_almost_full
);

  localparam logic [CNT_W-1:0]  c_BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [8:0]        c_BURST_LEN = 9'(BURST_LEN);
  localparam logic [ADDR_W-1:0] c_WORD_MSK  = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [8:0]          r_len;
  logic [8:0]          r_beat_cnt;
  logic                r_settle;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic                r_arvalid;

  logic [8:0]          w_next_len;
  logic                w_rready;
  logic                w_accept;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_len_bytes;

  always_comb begin
    w_next_len = c_BURST_LEN;
    if (r_remaining < c_BURST_CNT) begin
      w_next_len = r_remaining[8:0];
    end
  end

  assign w_rready    = (r_state == S_DATA) && !fifo_full;
  assign w_accept    = w_rready && m_rvalid;
  assign w_last_beat = (r_beat_cnt == (r_len - 9'd1));
  assign w_len_bytes = ADDR_W'({r_len, 2'b00});

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign m_araddr     = r_araddr;
  assign m_arlen      = r_arlen;
  assign m_arvalid    = r_arvalid;
  assign m_rready     = w_rready;
  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = (r_state == S_DATA) ? m_rdata : '0;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_settle    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr & c_WORD_MSK;
            r_remaining <= total_beats;
            r_err       <= 1'b0;
            if (total_beats == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Almost-full low guarantees room for a whole burst.
          if (!fifo_almost_full && !fifo_full) begin
            r_len     <= w_next_len;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_next_len - 9'd1);
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_arready) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_addr     <= r_addr + w_len_bytes;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_beat_cnt  <= r_beat_cnt + 9'd1;
            r_remaining <= r_remaining - CNT_W'(1);
            // Beat count ends the burst; rlast is only cross-checked.
            if ((m_rresp != 2'b00) || (m_rlast != w_last_beat)) begin
              r_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_settle <= 1'b0;
              r_state  <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (!r_settle) begin
            r_settle <= 1'b1;
          end else if (r_remaining == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_rfifo_filler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rfifo_filler
// Brief    : Randomised AXI read-slave environment with a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rfifo_filler;

  localparam int AW = 28;
  localparam int CW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] total = '0;
  logic          busy, done, err;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full = 1'b0;
  logic          af = 1'b0;

  ddr_rfifo_filler #(.ADDR_W(AW), .CNT_W(CW), .BURST_LEN(4), .DATA_W(DW)) u_dut (
    .wr_clk(clk), .wr_rst(rst), .start(start), .base_addr(base), .total_beats(total),
    .busy(busy), .done(done), .err(err),
    .m_araddr(araddr), .m_arlen(arlen), .m_arvalid(arvalid), .m_arready(arready),
    .m_rdata(rdata), .m_rresp(rresp), .m_rlast(rlast), .m_rvalid(rvalid), .m_rready(rready),
    .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_full(full), .fifo_almost_full(af)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment knobs, written only by the main sequence.
  int ar_mode = 0;
  int r_gap = 0;
  int full_rand = 0;
  int rresp_beat = -1;
  int early_beat = -1;
  int xfer_rhs0 = 0;

  // Observations, written only by the monitor.
  logic [AW+7:0] ar_q[$];
  logic [DW-1:0] wr_q[$];
  int ndone = 0;
  int rhs_cnt = 0;
  int v_full = 0, v_wren = 0, v_data = 0, v_hold = 0, v_busy = 0, v_donew = 0;
  logic rst_seen = 1'b1;

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle what the DUT will see at the next rising edge.
  initial begin
    logic          prev_av, prev_ar, prev_done;
    logic [AW+7:0] prev_info;
    prev_av = 1'b0; prev_ar = 1'b0; prev_done = 1'b0; prev_info = '0;
    forever begin
      @(negedge clk);
      rst_seen = rst;
      if (!rst) begin
        if (full && (rready || wr_en)) v_full++;
        if (wr_en != (rvalid && rready)) v_wren++;
        if (rvalid && rready) rhs_cnt++;
        if (wr_en) begin
          if (wr_data != rdata) v_data++;
          wr_q.push_back(wr_data);
        end
        if (prev_av && !prev_ar && (!arvalid || {araddr, arlen} != prev_info)) v_hold++;
        if (arvalid && arready) ar_q.push_back({araddr, arlen});
        if (done) begin
          ndone++;
          if (busy) v_busy++;
          if (prev_done) v_donew++;
        end
      end
      prev_av = arvalid; prev_ar = arready; prev_info = {araddr, arlen}; prev_done = done;
    end
  end

  // AXI read slave: serves bursts in AR order with data derived from address.
  initial begin
    int sidx, bidx, taken, ar_wait, gb;
    bit acc;
    logic [AW-1:0] a;
    sidx = 0; bidx = 0; taken = 0; ar_wait = 0;
    forever begin
      step();
      if (rst_seen) begin
        sidx = ar_q.size(); bidx = 0; taken = rhs_cnt; ar_wait = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
      end else begin
        acc = 1'b0;
        if (rhs_cnt > taken) begin
          acc = 1'b1;
          if (bidx == int'(ar_q[sidx][7:0])) begin
            sidx++; bidx = 0;
          end else begin
            bidx++;
          end
          taken++;
        end
        case (ar_mode)
          0: arready = 1'b1;
          1: begin
            arready = arvalid && (ar_wait >= 7);
            ar_wait = arvalid ? ar_wait + 1 : 0;
          end
          default: arready = 1'($urandom % 2);
        endcase
        if (rvalid && !acc) begin
          rvalid = 1'b1;
        end else if (sidx < ar_q.size() && (r_gap == 0 || ($urandom % 3) != 0)) begin
          gb     = taken - xfer_rhs0;
          a      = ar_q[sidx][AW+7:8] + AW'(4 * bidx);
          rvalid = 1'b1;
          rdata  = fdat(a);
          rlast  = (bidx == int'(ar_q[sidx][7:0])) ^ (gb == early_beat);
          rresp  = (gb == rresp_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          rresp  = 2'b00;
        end
      end
    end
  end

  // FIFO full flag: random toggling when enabled.
  initial forever begin
    step();
    full = (full_rand != 0) && (($urandom % 4) == 0);
  end

  // inj: 0 none, 1 second start while busy, 2 almost-full hold, 3 reset in DATA
  task automatic run(input logic [AW-1:0] b, input int n, input bit exp_err, input int inj);
    int ar0, wr0, d0, hold, rem, m, idx;
    bit got, held;
    logic [AW-1:0] a, a0;
    ar0 = ar_q.size(); wr0 = wr_q.size(); d0 = ndone; xfer_rhs0 = rhs_cnt;
    base = b; total = CW'(n); start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0; held = 1'b0; hold = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (inj == 1 && k == 5) begin start = 1'b1; base = 28'h0F00; total = 20'd3; end
      if (inj == 1 && k == 6) start = 1'b0;
      if (inj == 2 && !held && (wr_q.size() - wr0) >= 4) begin
        af = 1'b1; held = 1'b1; hold = 50;
      end else if (inj == 2 && hold > 0) begin
        hold--;
        if (hold == 0) begin
          chk("af_hold_ar_count", 64'(ar_q.size() - ar0), 64'd1);
          chk("af_hold_arvalid", 64'(arvalid), 64'd0);
          af = 1'b0;
          step();
          chk("ar_after_release", 64'(arvalid), 64'd1);
        end
      end
      if (inj == 3 && (wr_q.size() - wr0) >= 2) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ctl", 64'({busy, done, err, arvalid, rready, wr_en}), 64'd0);
        chk("rst_ar", 64'({araddr, arlen}), 64'd0);
        chk("rst_wdata", 64'(wr_data), 64'd0);
        step();
        return;
      end
      step();
      if (ndone != d0) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
    a0 = b & ~AW'(3);
    a = a0; rem = n; idx = ar0;
    chk("ar_count", 64'(ar_q.size() - ar0), 64'((n + 3) / 4));
    while (rem > 0) begin
      m = (rem < 4) ? rem : 4;
      if (idx < ar_q.size()) chk("ar_addr_len", 64'(ar_q[idx]), 64'({a, 8'(m - 1)}));
      idx++; a = a + AW'(4 * m); rem = rem - m;
    end
    chk("wr_count", 64'(wr_q.size() - wr0), 64'(n));
    for (int i = 0; i < n && (wr0 + i) < wr_q.size(); i++)
      chk("wr_data", 64'(wr_q[wr0 + i]), 64'(fdat(a0 + AW'(4 * i))));
    chk("err", 64'(err), 64'(exp_err));
    chk("busy_end", 64'(busy), 64'd0);
    chk("wr_while_full", 64'(v_full), 64'd0);
    chk("wren_vs_handshake", 64'(v_wren), 64'd0);
    chk("wdata_passthru", 64'(v_data), 64'd0);
    chk("ar_stable", 64'(v_hold), 64'd0);
    chk("busy_at_done", 64'(v_busy), 64'd0);
    chk("done_width", 64'(v_donew), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    int ar0, d0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_ctl", 64'({busy, done, err, arvalid, rready, wr_en}), 64'd0);
    chk("reset_ar", 64'({araddr, arlen}), 64'd0);

    run(28'h100, 10, 1'b0, 0);

    ar0 = ar_q.size(); d0 = ndone;
    total = '0; base = 28'h500; start = 1'b1;
    step();
    start = 1'b0;
    chk("zl_done", 64'(done), 64'd1);
    chk("zl_busy", 64'({busy, arvalid}), 64'd0);
    step();
    step();
    chk("zl_done_off", 64'(done), 64'd0);
    chk("zl_no_ar", 64'(ar_q.size() - ar0), 64'd0);

    run(28'h200, 12, 1'b0, 2);

    full_rand = 1; r_gap = 1;
    run(28'h400, 9, 1'b0, 0);
    full_rand = 0; r_gap = 0;

    rresp_beat = 2;
    run(28'h1000, 4, 1'b1, 0);
    rresp_beat = -1;
    early_beat = 1;
    run(28'h2000, 8, 1'b1, 0);
    early_beat = -1;
    run(28'h3000, 5, 1'b0, 0);

    run(28'h4000, 11, 1'b0, 1);
    run(28'h5000, 16, 1'b0, 3);
    run(28'h6000, 6, 1'b0, 0);

    ar_mode = 1;
    run(28'h7000, 8, 1'b0, 0);
    ar_mode = 0;
    run(28'h103, 5, 1'b0, 0);
    run(28'hFFF_FFF0, 10, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      ar_mode   = int'($urandom_range(0, 2));
      r_gap     = int'($urandom % 2);
      full_rand = int'($urandom % 2);
      rb        = AW'($urandom) & ~AW'(15);
      run(rb, int'($urandom_range(1, 21)), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
